// File: rtl/iic_share_arb.sv
// iic_share_arb
//  Shares one I2C byte master (16-bit register address) between two config
//  clients: port 0 = HDMI-TX config controller, port 1 = audio codec poller.
//  Round-robin arbitration, one byte transaction per grant. The arbiter
//  latches the owner's request fields into the master registers, pulses
//  iic_trig, supervises busy with start/transfer timeouts, and returns a
//  done/err pulse plus read data to the owner.
//
//  Ports
//   clk, rstn                  clock, async active-low reset
//   req*/wr*/dev*/addr*/wd*    client request (level) and access fields
//   done*/err*                 1-cycle completion / abort pulses
//   rdata                      data_out captured at completion
//   grant                      one-hot owner, 2'b00 when idle
//   iic_trig/w_r/device_id/addr/data_in   master command interface
//   busy/data_out              master status and read data
//
//  Optional feature (macro IIC_ARB_LOCK_EN): lock0/lock1 inputs keep the
//  grant with the owner across accesses for atomic multi-byte sequences.
module iic_share_arb #(
  parameter int unsigned TO_W     = 22,
  parameter int unsigned START_TO = 1000,
  parameter int unsigned XFER_TO  = 32'h30D400
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req0,
  input  logic        req1,
  input  logic        wr0,
  input  logic        wr1,
  input  logic [7:0]  dev0,
  input  logic [7:0]  dev1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [7:0]  wd0,
  input  logic [7:0]  wd1,
`ifdef IIC_ARB_LOCK_EN
  input  logic        lock0,
  input  logic        lock1,
`endif
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic [7:0]  rdata,
  output logic [1:0]  grant,
  output logic        iic_trig,
  output logic        w_r,
  output logic [7:0]  device_id,
  output logic [15:0] addr,
  output logic [7:0]  data_in,
  input  logic        busy,
  input  logic [7:0]  data_out
);

  localparam logic [TO_W-1:0] START_LIM = TO_W'(START_TO - 1);
  localparam logic [TO_W-1:0] XFER_LIM  = TO_W'(XFER_TO - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_TRIG, S_WBUSY, S_WDONE, S_DONE, S_ABORT
  } state_e;

  state_e          state_q;
  logic [1:0]      grant_q;
  logic            owner_q;
  logic            rr_q;       // port preferred when both request
  logic            busy_1d_q;
  logic [TO_W-1:0] cnt_q;
  logic            trig_q, w_r_q;
  logic [7:0]      dev_q, wd_q, rdata_q;
  logic [15:0]     addr_q;
  logic            done0_q, done1_q, err0_q, err1_q;

  logic            pick, sel, held, keep_grant;
  logic            sel_wr;
  logic [7:0]      sel_dev, sel_wd;
  logic [15:0]     sel_addr;

  // Contested requests go to rr_q; otherwise whoever asks.
  assign pick = (req0 && req1) ? rr_q : req1;

`ifdef IIC_ARB_LOCK_EN
  logic own_lock, own_req;
  assign own_lock   = owner_q ? lock1 : lock0;
  assign own_req    = owner_q ? req1  : req0;
  // A grant still set while IDLE means the owner holds a lock.
  assign held       = (grant_q != 2'b00);
  assign keep_grant = own_lock;
`else
  assign held       = 1'b0;
  assign keep_grant = 1'b0;
`endif

  assign sel      = held ? owner_q : pick;
  assign sel_wr   = sel ? wr1   : wr0;
  assign sel_dev  = sel ? dev1  : dev0;
  assign sel_addr = sel ? addr1 : addr0;
  assign sel_wd   = sel ? wd1   : wd0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      grant_q   <= 2'b00;
      owner_q   <= 1'b0;
      rr_q      <= 1'b0;
      busy_1d_q <= 1'b0;
      cnt_q     <= '0;
      trig_q    <= 1'b0;
      w_r_q     <= 1'b1;
      dev_q     <= 8'h00;
      addr_q    <= 16'h0000;
      wd_q      <= 8'h00;
      rdata_q   <= 8'h00;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
    end else begin
      busy_1d_q <= busy;
      case (state_q)
        S_IDLE: begin
`ifdef IIC_ARB_LOCK_EN
          if (held) begin
            if (!own_lock) begin
              grant_q <= 2'b00;
            end else if (own_req && !busy) begin
              w_r_q   <= sel_wr;
              dev_q   <= sel_dev;
              addr_q  <= sel_addr;
              wd_q    <= sel_wd;
              state_q <= S_SETUP;
            end
          end else
`endif
          // A foreign master owning the bus keeps us out until it is free.
          if ((req0 || req1) && !busy) begin
            owner_q <= pick;
            grant_q <= pick ? 2'b10 : 2'b01;
            rr_q    <= ~pick;
            w_r_q   <= sel_wr;
            dev_q   <= sel_dev;
            addr_q  <= sel_addr;
            wd_q    <= sel_wd;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: state_q <= S_TRIG;
        S_TRIG: begin
          trig_q  <= 1'b1;
          cnt_q   <= '0;
          state_q <= S_WBUSY;
        end
        S_WBUSY: begin
          trig_q <= 1'b0;
          if (busy) begin
            cnt_q   <= '0;
            state_q <= S_WDONE;
          end else if (cnt_q == START_LIM) begin
            err0_q  <= ~owner_q;
            err1_q  <= owner_q;
            grant_q <= keep_grant ? grant_q : 2'b00;
            state_q <= S_ABORT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_WDONE: begin
          if (busy_1d_q && !busy) begin
            rdata_q <= data_out;
            done0_q <= ~owner_q;
            done1_q <= owner_q;
            grant_q <= keep_grant ? grant_q : 2'b00;
            state_q <= S_DONE;
          end else if (cnt_q == XFER_LIM) begin
            err0_q  <= ~owner_q;
            err1_q  <= owner_q;
            grant_q <= keep_grant ? grant_q : 2'b00;
            state_q <= S_ABORT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          state_q <= S_IDLE;
        end
        S_ABORT: begin
          err0_q  <= 1'b0;
          err1_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign done0     = done0_q;
  assign done1     = done1_q;
  assign err0      = err0_q;
  assign err1      = err1_q;
  assign rdata     = rdata_q;
  assign grant     = grant_q;
  assign iic_trig  = trig_q;
  assign w_r       = w_r_q;
  assign device_id = dev_q;
  assign addr      = addr_q;
  assign data_in   = wd_q;

endmodule
